// File: rtl/risc_pkg.sv
// Shared constants for the Simple-RISC control path:
// ISA opcodes, sequencer phase numbers and field widths.
package risc_pkg;

  localparam int OPW = 3;
  localparam int PHW = 3;

  localparam logic [OPW-1:0] OP_HLT = 3'd0;
  localparam logic [OPW-1:0] OP_SKZ = 3'd1;
  localparam logic [OPW-1:0] OP_ADD = 3'd2;
  localparam logic [OPW-1:0] OP_AND = 3'd3;
  localparam logic [OPW-1:0] OP_XOR = 3'd4;
  localparam logic [OPW-1:0] OP_LDA = 3'd5;
  localparam logic [OPW-1:0] OP_STO = 3'd6;
  localparam logic [OPW-1:0] OP_JMP = 3'd7;

  localparam logic [PHW-1:0] PH_INST_ADDR  = 3'd0;
  localparam logic [PHW-1:0] PH_INST_FETCH = 3'd1;
  localparam logic [PHW-1:0] PH_INST_LOAD  = 3'd2;
  localparam logic [PHW-1:0] PH_IDLE       = 3'd3;
  localparam logic [PHW-1:0] PH_OP_ADDR    = 3'd4;
  localparam logic [PHW-1:0] PH_OP_FETCH   = 3'd5;
  localparam logic [PHW-1:0] PH_ALU_OP     = 3'd6;
  localparam logic [PHW-1:0] PH_STORE      = 3'd7;

endpackage

// File: rtl/phase_counter.sv
// Free-running phase counter with enable;
// wraps naturally at 2**W, cleared asynchronously.
module phase_counter
  import risc_pkg::*;
#(
  parameter int W = PHW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Eight-phase instruction sequencer: phase counter,
// sticky halt flag and per-phase datapath control decode.
module control_sequencer
  import risc_pkg::*;
#(
  parameter int OPW = risc_pkg::OPW,
  parameter int PHW = risc_pkg::PHW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           step_en,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           sel,
  output logic           rd,
  output logic           wr,
  output logic           ld_ir,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           ld_ac,
  output logic           data_e,
  output logic           halt,
  output logic [PHW-1:0] phase
);

  logic halted;
  logic adv;
  logic hlt_now;
  logic is_hlt;
  logic is_skz;
  logic is_sto;
  logic is_jmp;
  logic alu_op;
  logic op_ok;

  // op_ok stays low for an unresolvable opcode
  always_comb begin
    is_hlt = 1'b0;
    is_skz = 1'b0;
    is_sto = 1'b0;
    is_jmp = 1'b0;
    alu_op = 1'b0;
    op_ok  = 1'b1;
    case (opcode)
      OP_HLT: is_hlt = 1'b1;
      OP_SKZ: is_skz = 1'b1;
      OP_ADD: alu_op = 1'b1;
      OP_AND: alu_op = 1'b1;
      OP_XOR: alu_op = 1'b1;
      OP_LDA: alu_op = 1'b1;
      OP_STO: is_sto = 1'b1;
      OP_JMP: is_jmp = 1'b1;
      default: op_ok = 1'b0;
    endcase
  end

  assign hlt_now = (phase == PH_OP_ADDR) && is_hlt;
  assign adv     = step_en && !halted && !hlt_now;

  phase_counter #(
    .W(PHW)
  ) u_phase (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .count(phase)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted <= 1'b0;
    end else if (step_en && hlt_now) begin
      halted <= 1'b1;
    end
  end

  assign halt = halted || hlt_now;

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    data_e = 1'b0;
    if (!halted) begin
      unique case (phase)
        PH_INST_ADDR: sel = 1'b1;
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: inc_pc = op_ok;
        PH_OP_FETCH: rd = alu_op;
        PH_ALU_OP: begin
          rd     = alu_op;
          inc_pc = is_skz && zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        PH_STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          inc_pc = is_jmp;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: vector table
// per instruction plus halt, hold and reset sequences.
module tb_control_sequencer;
  import risc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       step_en;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, wr, ld_ir, inc_pc;
  logic       ld_pc, ld_ac, data_e, halt;
  logic [2:0] phase;
  logic [8:0] ctrl;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [2:0] ph;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  control_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .step_en(step_en),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  always #5 clk = ~clk;

  // {sel,rd,wr,ld_ir,inc_pc,ld_pc,ld_ac,data_e,halt}
  assign ctrl = {sel, rd, wr, ld_ir, inc_pc,
                 ld_pc, ld_ac, data_e, halt};

  localparam logic [8:0] C0 = 9'b100000000;
  localparam logic [8:0] C1 = 9'b110000000;
  localparam logic [8:0] C2 = 9'b110100000;
  localparam logic [8:0] C4 = 9'b000010000;
  localparam logic [8:0] CRD = 9'b010000000;
  localparam logic [8:0] CAC = 9'b010000100;
  localparam logic [8:0] CDE = 9'b000000010;
  localparam logic [8:0] CWR = 9'b001000010;
  localparam logic [8:0] CLP = 9'b000001000;
  localparam logic [8:0] CJ7 = 9'b000011000;
  localparam logic [8:0] CNONE = 9'b000000000;

  function automatic void add_inst(
    input logic [2:0] op, input logic z,
    input logic [8:0] c5, input logic [8:0] c6,
    input logic [8:0] c7);
    logic [8:0] e [8];
    e = '{C0, C1, C2, C2, C4, c5, c6, c7};
    for (int p = 0; p < 8; p++)
      vecs.push_back('{op, z, 3'(p), e[p]});
  endfunction

  task automatic chk(input string name,
                     input logic [8:0] got,
                     input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b",
               name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    step_en = 1'b0;
    opcode = OP_ADD;
    zero = 1'b0;
    #2;
    chk("reset_phase", 9'(phase), 9'd0);
    chk("reset_ctrl", ctrl, C0);
    tick();
    rst = 1'b1;

    add_inst(OP_ADD, 1'b0, CRD, CRD, CAC);
    add_inst(OP_STO, 1'b0, CNONE, CDE, CWR);
    add_inst(OP_SKZ, 1'b1, CNONE, C4, CNONE);
    add_inst(OP_SKZ, 1'b0, CNONE, CNONE, CNONE);
    add_inst(OP_JMP, 1'b0, CNONE, CLP, CJ7);
    add_inst(OP_XOR, 1'b1, CRD, CRD, CAC);

    foreach (vecs[i]) begin
      step_en = 1'b1;
      opcode = vecs[i].op;
      zero = vecs[i].z;
      #1;
      chk($sformatf("vec%0d_phase", i),
          9'(phase), 9'(vecs[i].ph));
      chk($sformatf("vec%0d_ctrl", i),
          ctrl, vecs[i].exp);
      if (rd && wr)
        chk($sformatf("vec%0d_rdwr", i),
            9'({rd, wr}), 9'b10);
      tick();
    end

    // halt: freeze at phase 4 with only halt high
    opcode = OP_HLT;
    zero = 1'b0;
    repeat (4) tick();
    chk("hlt_pre_phase", 9'(phase), 9'd4);
    chk("hlt_pre_ctrl", ctrl, 9'b000010001);
    tick();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("hlt%0d_phase", k),
          9'(phase), 9'd4);
      chk($sformatf("hlt%0d_ctrl", k),
          ctrl, 9'b000000001);
      tick();
    end
    rst = 1'b0;
    #1;
    chk("hlt_rst_phase", 9'(phase), 9'd0);
    chk("hlt_rst_ctrl", ctrl, C0);
    rst = 1'b1;

    // step_en low holds phase 5
    opcode = OP_ADD;
    repeat (5) tick();
    chk("hold_pre_phase", 9'(phase), 9'd5);
    chk("hold_pre_ctrl", ctrl, CRD);
    step_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold%0d_phase", k),
          9'(phase), 9'd5);
      chk($sformatf("hold%0d_ctrl", k),
          ctrl, CRD);
    end
    step_en = 1'b1;
    repeat (2) tick();
    chk("hold_post_phase", 9'(phase), 9'd7);
    chk("hold_post_ctrl", ctrl, CAC);
    tick();

    // async reset in STO phase 7 kills wr at once
    opcode = OP_STO;
    repeat (7) tick();
    chk("sto7_phase", 9'(phase), 9'd7);
    chk("sto7_ctrl", ctrl, CWR);
    #1;
    rst = 1'b0;
    #1;
    chk("sto_rst_wr", 9'(wr), 9'd0);
    chk("sto_rst_ctrl", ctrl, C0);
    chk("sto_rst_phase", 9'(phase), 9'd0);
    rst = 1'b1;
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("sto_re%0d_phase", p),
          9'(phase), 9'(p));
      chk($sformatf("sto_re%0d_wr", p),
          9'(wr), 9'(p == 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
